// File: rtl/reset_catch_pkg.sv
// +------------------------------------------------------------------+
// | reset_catch_pkg: FSM states and counter sizing for the sequencer |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

package reset_catch_pkg;

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  // Bits needed to hold 0..max_count, never narrower than one bit.
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/reset_catch_sequencer_if.sv
// +------------------------------------------------------------------+
// | reset_catch_sequencer_if: request inputs and reset outputs       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

interface reset_catch_sequencer_if #(
  parameter int N_CH = 4
);

  logic            io_req;
  logic [N_CH-1:0] io_ch_req;
  logic [N_CH-1:0] io_sync_reset;
  logic            io_done;

  modport master (
    output io_req,
    output io_ch_req,
    input  io_sync_reset,
    input  io_done
  );

  modport slave (
    input  io_req,
    input  io_ch_req,
    output io_sync_reset,
    output io_done
  );

endinterface

`default_nettype wire

// File: rtl/reset_sync_chain.sv
// +------------------------------------------------------------------+
// | reset_sync_chain: DEPTH-flop synchroniser, clears on reset low   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module reset_sync_chain #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int s = 0; s < DEPTH; s++) r_stage[s] <= '0;
    end else begin
      r_stage[0] <= d;
      for (int s = 1; s < DEPTH; s++) r_stage[s] <= r_stage[s-1];
    end
  end

  assign q = r_stage[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/reset_catch_sequencer.sv
// +------------------------------------------------------------------+
// | reset_catch_sequencer: sync, hold and staggered channel release  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module reset_catch_sequencer
  import reset_catch_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_DEPTH  = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGGER     = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  reset_catch_sequencer_if.slave  bus
);

  localparam int C_HOLD_W = cnt_width(HOLD_CYCLES - 1);
  localparam int C_STAG_W = cnt_width((N_CH - 1) * STAGGER);
  localparam int C_CH_W   = cnt_width(HOLD_CYCLES);

  localparam logic [C_HOLD_W-1:0] C_HOLD_LAST = C_HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [C_STAG_W-1:0] C_STAG_LAST = C_STAG_W'((N_CH - 1) * STAGGER);
  // A channel counts one extra step so it releases HOLD_CYCLES edges after
  // its first synced-low edge, matching the global hold-to-release spacing.
  localparam logic [C_CH_W-1:0]   C_CH_LAST   = C_CH_W'(HOLD_CYCLES);

  logic            w_req;
  logic [N_CH-1:0] w_ch_req;

  state_t              r_state;
  logic [C_HOLD_W-1:0] r_hold;
  logic [C_STAG_W-1:0] r_stag;
  logic [C_CH_W-1:0]   r_ch_cnt [N_CH];
  logic [N_CH-1:0]     r_sync_reset;
  logic                r_done;

  reset_sync_chain #(.WIDTH(1), .DEPTH(SYNC_DEPTH)) u_req_sync (
    .clock (clock),
    .reset (reset),
    .d     (bus.io_req),
    .q     (w_req)
  );

  reset_sync_chain #(.WIDTH(N_CH), .DEPTH(SYNC_DEPTH)) u_ch_sync (
    .clock (clock),
    .reset (reset),
    .d     (bus.io_ch_req),
    .q     (w_ch_req)
  );

  always_ff @(posedge clock) begin
    if (!reset || w_req) begin
      r_state      <= ASSERT;
      r_hold       <= '0;
      r_stag       <= '0;
      for (int i = 0; i < N_CH; i++) r_ch_cnt[i] <= '0;
      r_sync_reset <= '1;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        ASSERT: begin
          r_sync_reset <= '1;
          r_done       <= 1'b0;
          r_stag       <= '0;
          for (int i = 0; i < N_CH; i++) r_ch_cnt[i] <= '0;
          if (r_hold == C_HOLD_LAST) begin
            r_state <= RELEASE;
            r_hold  <= '0;
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end

        RELEASE: begin
          for (int i = 0; i < N_CH; i++) begin
            if (r_stag == C_STAG_W'(i * STAGGER)) r_sync_reset[i] <= 1'b0;
          end
          if (r_stag == C_STAG_LAST) begin
            r_state <= RUN;
            r_done  <= 1'b1;
          end else begin
            r_stag <= r_stag + 1'b1;
          end
        end

        RUN: begin
          r_done <= 1'b1;
          for (int i = 0; i < N_CH; i++) begin
            if (w_ch_req[i]) begin
              r_sync_reset[i] <= 1'b1;
              r_ch_cnt[i]     <= '0;
            end else if (r_sync_reset[i]) begin
              if (r_ch_cnt[i] == C_CH_LAST) begin
                r_sync_reset[i] <= 1'b0;
                r_ch_cnt[i]     <= '0;
              end else begin
                r_ch_cnt[i] <= r_ch_cnt[i] + 1'b1;
              end
            end
          end
        end

        default: begin
          r_state      <= ASSERT;
          r_sync_reset <= '1;
          r_done       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.io_sync_reset = r_sync_reset;
  assign bus.io_done       = r_done;

endmodule

`default_nettype wire

// File: doc/reset_catch_sequencer.md
# reset_catch_sequencer

Parametrised, multi-channel successor to the single-output reset catch-and-sync. It synchronises a global reset request and one request per channel, holds every reset for a minimum assertion time, and releases the channel resets in a fixed staggered order (channel 0 first). It sits at the top of a clock domain and drives the reset of each downstream subsystem. It reports sequence completion to power/boot control.

## Interface
Parameters:
- N_CH, default 4: number of reset output channels; must be ≥1.
- SYNC_DEPTH, default 3: synchroniser flops per request input; must be ≥2.
- HOLD_CYCLES, default 16: minimum assertion length, in clock cycles, after a request is removed; must be ≥1.
- STAGGER, default 4: cycles between consecutive channel releases; must be ≥1.

Ports:
- clock, input, 1: sole clock. Every flop samples on the rising edge.
- reset, input, 1: synchronous, active-low reset.
- io_req, input, 1: global reset request, active-high; asynchronous to clock.
- io_ch_req, input, N_CH: per-channel reset requests, active-high; asynchronous to clock.
- io_sync_reset, output, N_CH: per-channel synchronous resets, active-high, registered.
- io_done, output, 1: global release sequence complete, registered.

## Operation
- Each of io_req and io_ch_req[i] passes through a SYNC_DEPTH-flop chain. On reset, every chain clears to 0.
- Reset behaviour: at an edge with reset=0:
  - FSM goes to ASSERT.
  - Hold and stagger counters clear to 0.
  - io_sync_reset becomes all ones.
  - io_done becomes 0.
- ASSERT state:
  - All outputs are held at 1.
  - The hold counter increments each cycle while synced io_req=0.
  - When synced io_req=1, the hold counter clears.
  - When the counter reaches HOLD_CYCLES-1, the FSM goes to RELEASE.
- RELEASE state:
  - Channel 0 is released on entry.
  - Channel i is released i*STAGGER cycles after entry.
  - The FSM goes to RUN on the same edge that releases channel N_CH-1.
  - With N_CH=1, the FSM goes directly to RUN.
- RUN state:
  - io_done=1.
  - Per-channel handling is active (see below).
- Global request wins in every state. When synced io_req=1:
  - On the next edge, the FSM returns to ASSERT.
  - All io_sync_reset bits go to 1.
  - io_done goes to 0.
  - All counters clear.
- Per-channel handling, in RUN only:
  - When synced io_ch_req[i]=1, io_sync_reset[i] goes to 1 on the next edge and that channel's hold counter clears.
  - The channel is released HOLD_CYCLES cycles after its synced request returns to 0.
  - If the request reasserts during the hold, the hold counter restarts.
  - Other channels and io_done are unaffected.
- In ASSERT and RELEASE, io_ch_req is ignored; the channel counters stay cleared.
- Counter widths: $clog2 of the maximum count + 1. Counters saturate and never wrap.

## Timing
- Edge numbering: edge 0 is the first edge with reset=1, with io_req=0 and synced io_req=0.
- From edge 0, with default parameters:
  - io_sync_reset[i] falls after edge HOLD_CYCLES + i*STAGGER, i.e. 16, 20, 24, 28.
  - io_done rises after edge HOLD_CYCLES + (N_CH-1)*STAGGER, i.e. 28.
- Assertion latency: if io_req or io_ch_req[i] is first sampled 1 at edge k, the affected outputs are 1 after edge k+SYNC_DEPTH.
- Minimum reset pulse: a 1-cycle request still produces an output assertion of at least HOLD_CYCLES cycles.
- Simultaneous events:
  - A global request arriving on the same edge as a channel release: the global request wins.
  - Reset=0 arriving during any state overrides everything on that edge.

## Structure
- Package reset_catch_pkg contains:
  - the typedef enum for the FSM states {ASSERT, RELEASE, RUN};
  - the function that derives counter widths from the parameters.
- Sub-module reset_sync_chain, parametrised by WIDTH and DEPTH:
  - a plain flop shift chain with synchronous active-low clear to 0;
  - instantiated once for io_req and once for io_ch_req (WIDTH=N_CH).
- The top level holds the FSM, the global hold and stagger counters, and N_CH per-channel hold counters.

## Test plan
- Power-on: hold reset=0 for 5 cycles, then release with io_req=0 → outputs all 1 during reset; channels release after edges 16/20/24/28; io_done rises after edge 28.
- Global request mid-RELEASE: pulse io_req for 1 cycle at edge 21 → all outputs 1 after edge 24; io_done=0; the full sequence reruns from the hold.
- Channel request in RUN: pulse io_ch_req[2] for 3 cycles → io_sync_reset[2] asserts 3 cycles after the first sample and stays high ≥16 cycles after the synced request falls; other channels and io_done stay unchanged.
- Channel request re-asserted during its hold → the hold restarts; release occurs 16 cycles after the last synced low.
- Channel request during ASSERT → ignored; after RUN is reached, a still-high request asserts only that channel.
- Parameter corners: N_CH=1, SYNC_DEPTH=2, HOLD_CYCLES=1, STAGGER=1 → channel 0 releases after edge 1; io_done rises on the same edge.
